// File: rtl/register_status_file.sv
// Architectural register file with per-register rename status (busy/tag) for a Tomasulo core.
// Captures matching CDB broadcasts, renames destinations at issue, and serves operands with CDB bypass.
module register_status_file #(
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_TAG            = 4,
  parameter int NUM_REG           = 32,
  parameter int BW_REG_ADDR       = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_cdb_valid,
  input  logic [BW_TAG-1:0]            i_cdb_tag,
  input  logic [BW_PROCESSOR_DATA-1:0] i_cdb_data,
  input  logic                         i_issue_valid,
  output logic                         o_issue_ready,
  input  logic [BW_REG_ADDR-1:0]       i_issue_rs1,
  input  logic [BW_REG_ADDR-1:0]       i_issue_rs2,
  input  logic [BW_REG_ADDR-1:0]       i_issue_rd,
  input  logic                         i_issue_rd_we,
  input  logic [BW_TAG-1:0]            i_issue_tag,
  output logic                         o_rs1_busy,
  output logic                         o_rs2_busy,
  output logic [BW_TAG-1:0]            o_rs1_tag,
  output logic [BW_TAG-1:0]            o_rs2_tag,
  output logic [BW_PROCESSOR_DATA-1:0] o_rs1_data,
  output logic [BW_PROCESSOR_DATA-1:0] o_rs2_data,
  input  logic                         i_flush
);

  logic [BW_PROCESSOR_DATA-1:0] data_q [NUM_REG];
  logic [BW_PROCESSOR_DATA-1:0] data_d [NUM_REG];
  logic [BW_TAG-1:0]            tag_q  [NUM_REG];
  logic [BW_TAG-1:0]            tag_d  [NUM_REG];
  logic [NUM_REG-1:0]           busy_q;
  logic [NUM_REG-1:0]           busy_d;

  logic                         issue_fire;
  logic [BW_REG_ADDR-1:0]       src_idx  [2];
  logic                         src_busy [2];
  logic [BW_TAG-1:0]            src_tag  [2];
  logic [BW_PROCESSOR_DATA-1:0] src_data [2];

  assign o_issue_ready = !i_flush;
  assign issue_fire    = i_issue_valid && o_issue_ready;

  assign src_idx[0] = i_issue_rs1;
  assign src_idx[1] = i_issue_rs2;

  // Operand read sees pre-rename state; a same-cycle CDB match on the pending tag is bypassed.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      // NOTE: every output gets a default before the branches so no latch is inferred.
      src_busy[p] = 1'b0;
      src_tag[p]  = '0;
      src_data[p] = data_q[src_idx[p]];
      if (busy_q[src_idx[p]]) begin
        if (i_cdb_valid && (tag_q[src_idx[p]] == i_cdb_tag)) begin
          src_data[p] = i_cdb_data;
        end else begin
          src_busy[p] = 1'b1;
          src_tag[p]  = tag_q[src_idx[p]];
          src_data[p] = '0;
        end
      end
    end
  end

  assign o_rs1_busy = src_busy[0];
  assign o_rs1_tag  = src_tag[0];
  assign o_rs1_data = src_data[0];
  assign o_rs2_busy = src_busy[1];
  assign o_rs2_tag  = src_tag[1];
  assign o_rs2_data = src_data[1];

  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    for (int r = 1; r < NUM_REG; r++) begin
      // CDB match is judged on pre-flush, pre-rename status, so data captures even during flush.
      if (i_cdb_valid && busy_q[r] && (tag_q[r] == i_cdb_tag)) begin
        data_d[r] = i_cdb_data;
        busy_d[r] = 1'b0;
        tag_d[r]  = '0;
      end
      if (i_flush) begin
        busy_d[r] = 1'b0;
        tag_d[r]  = '0;
      end else if (issue_fire && i_issue_rd_we && (i_issue_rd == r[BW_REG_ADDR-1:0])) begin
        busy_d[r] = 1'b1;
        tag_d[r]  = i_issue_tag;
      end
    end
    data_d[0] = '0;
    busy_d[0] = 1'b0;
    tag_d[0]  = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data array is architecturally visible after reset (reads return 0), so it is
      // reset like any other flop rather than left as an unreset memory.
      for (int r = 0; r < NUM_REG; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      busy_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignment so all flops sample pre-edge values.
      data_q <= data_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_register_status_file.sv
// Self-checking bench for register_status_file: directed test-plan steps, then random traffic
// compared against a behavioural register/rename model.
module tb_register_status_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cdb_valid;
  logic [3:0]  i_cdb_tag;
  logic [31:0] i_cdb_data;
  logic        i_issue_valid;
  logic        o_issue_ready;
  logic [4:0]  i_issue_rs1, i_issue_rs2, i_issue_rd;
  logic        i_issue_rd_we;
  logic [3:0]  i_issue_tag;
  logic        o_rs1_busy, o_rs2_busy;
  logic [3:0]  o_rs1_tag, o_rs2_tag;
  logic [31:0] o_rs1_data, o_rs2_data;
  logic        i_flush;

  int checks = 0;
  int errors = 0;

  // Reference model: value, pending flag and producer tag per architectural register.
  logic [31:0] m_data [32];
  bit          m_busy [32];
  int          m_tag  [32];

  register_status_file dut (
    .clk(clk), .rst_n(rst_n),
    .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
    .i_issue_valid(i_issue_valid), .o_issue_ready(o_issue_ready),
    .i_issue_rs1(i_issue_rs1), .i_issue_rs2(i_issue_rs2),
    .i_issue_rd(i_issue_rd), .i_issue_rd_we(i_issue_rd_we), .i_issue_tag(i_issue_tag),
    .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
    .o_rs1_tag(o_rs1_tag), .o_rs2_tag(o_rs2_tag),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .i_flush(i_flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_data[r] = '0;
      m_busy[r] = 0;
      m_tag[r]  = 0;
    end
  endtask

  task automatic model_read(input int s, output logic [31:0] b, output logic [31:0] t,
                            output logic [31:0] d);
    if (m_busy[s] && i_cdb_valid && (int'(i_cdb_tag) == m_tag[s])) begin
      b = 0; t = 0; d = i_cdb_data;
    end else if (m_busy[s]) begin
      b = 1; t = m_tag[s]; d = 0;
    end else begin
      b = 0; t = 0; d = m_data[s];
    end
  endtask

  // Drive one cycle's inputs (we sit just after a falling edge), then compare all outputs.
  task automatic apply(input bit cv, input int ct, input logic [31:0] cd, input bit iv,
                       input int rs1, input int rs2, input int rd, input bit we,
                       input int it, input bit fl);
    logic [31:0] eb, et, ed;
    i_cdb_valid = cv; i_cdb_tag = 4'(ct); i_cdb_data = cd;
    i_issue_valid = iv; i_issue_rs1 = 5'(rs1); i_issue_rs2 = 5'(rs2);
    i_issue_rd = 5'(rd); i_issue_rd_we = we; i_issue_tag = 4'(it); i_flush = fl;
    #1;
    check("issue_ready", 32'(o_issue_ready), 32'(!fl));
    model_read(rs1, eb, et, ed);
    check("rs1_busy", 32'(o_rs1_busy), eb);
    check("rs1_tag", 32'(o_rs1_tag), et);
    check("rs1_data", o_rs1_data, ed);
    model_read(rs2, eb, et, ed);
    check("rs2_busy", 32'(o_rs2_busy), eb);
    check("rs2_tag", 32'(o_rs2_tag), et);
    check("rs2_data", o_rs2_data, ed);
  endtask

  // Advance the model by the rules for the currently driven inputs, then clock the DUT.
  task automatic tick();
    bit fire;
    fire = i_issue_valid && !i_flush;
    for (int r = 1; r < 32; r++) begin
      if (i_cdb_valid && m_busy[r] && m_tag[r] == int'(i_cdb_tag)) begin
        m_data[r] = i_cdb_data;
        m_busy[r] = 0;
      end
      if (i_flush) begin
        m_busy[r] = 0;
        m_tag[r]  = 0;
      end
    end
    if (fire && i_issue_rd_we && i_issue_rd != 0) begin
      m_busy[i_issue_rd] = 1;
      m_tag[i_issue_rd]  = int'(i_issue_tag);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int rs1, input int rs2);
    apply(0, 0, 0, 0, rs1, rs2, 0, 0, 0, 0);
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0;
    i_cdb_valid = 0; i_cdb_tag = 0; i_cdb_data = 0; i_issue_valid = 0;
    i_issue_rs1 = 0; i_issue_rs2 = 0; i_issue_rd = 0; i_issue_rd_we = 0;
    i_issue_tag = 0; i_flush = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, then a rename of x0 must be ignored.
    idle(5, 0);
    check("reset_rs1_data", o_rs1_data, 32'h0);
    apply(0, 0, 0, 1, 0, 0, 0, 1, 3, 0);
    tick();
    idle(0, 5);
    check("x0_busy", 32'(o_rs1_busy), 32'h0);

    // Rename r7 to tag 9, then broadcast.
    apply(0, 0, 0, 1, 1, 2, 7, 1, 9, 0);
    tick();
    idle(7, 0);
    check("r7_pending_busy", 32'(o_rs1_busy), 32'h1);
    check("r7_pending_tag", 32'(o_rs1_tag), 32'h9);
    apply(1, 9, 32'hDEADBEEF, 0, 7, 0, 0, 0, 0, 0);
    tick();
    idle(7, 0);
    check("r7_captured", o_rs1_data, 32'hDEADBEEF);
    check("r7_not_busy", 32'(o_rs1_busy), 32'h0);

    // Same-cycle bypass of a broadcast into a dependent read.
    apply(0, 0, 0, 1, 0, 0, 7, 1, 9, 0);
    tick();
    apply(1, 9, 32'd42, 1, 7, 7, 0, 0, 0, 0);
    check("bypass_busy", 32'(o_rs1_busy), 32'h0);
    check("bypass_data", o_rs1_data, 32'd42);
    tick();

    // Capture and rename on the same register: data captured, status renamed.
    apply(0, 0, 0, 1, 0, 0, 4, 1, 2, 0);
    tick();
    apply(1, 2, 32'd5, 1, 4, 0, 4, 1, 6, 0);
    tick();
    idle(4, 0);
    check("r4_renamed_busy", 32'(o_rs1_busy), 32'h1);
    check("r4_renamed_tag", 32'(o_rs1_tag), 32'h6);
    check("r4_data_probe", dut.data_q[4], 32'd5);

    // rd == rs1 of the same instruction reads the old mapping.
    apply(0, 0, 0, 1, 0, 0, 3, 1, 1, 0);
    tick();
    apply(1, 1, 32'd11, 0, 3, 0, 0, 0, 0, 0);
    tick();
    apply(0, 0, 0, 1, 3, 0, 3, 1, 1, 0);
    check("rd_eq_rs1_data", o_rs1_data, 32'd11);
    check("rd_eq_rs1_busy", 32'(o_rs1_busy), 32'h0);
    tick();
    idle(3, 0);
    check("r3_now_busy", 32'(o_rs1_busy), 32'h1);
    check("r3_now_tag", 32'(o_rs1_tag), 32'h1);

    // Flush together with an issue: issue refused, all renames dropped.
    apply(0, 0, 0, 1, 0, 0, 1, 1, 4, 0);
    tick();
    apply(0, 0, 0, 1, 0, 0, 2, 1, 5, 0);
    tick();
    apply(0, 0, 0, 1, 1, 2, 5, 1, 7, 1);
    check("flush_ready_low", 32'(o_issue_ready), 32'h0);
    tick();
    idle(1, 2);
    check("flush_r1_free", 32'(o_rs1_busy), 32'h0);
    check("flush_r2_free", 32'(o_rs2_busy), 32'h0);
    idle(5, 3);
    check("flush_r5_not_renamed", 32'(o_rs1_busy), 32'h0);

    // Random traffic on a small register window so tags collide and match often.
    for (int n = 0; n < 400; n++) begin
      int pr, ct;
      pr = $urandom_range(1, 7);
      ct = (m_busy[pr] && ($urandom_range(0, 3) != 0)) ? m_tag[pr] : $urandom_range(0, 15);
      apply($urandom_range(0, 1), ct, $urandom, $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 19) == 0);
      tick();
    end

    // Asynchronous reset mid-operation drops a pending rename immediately.
    apply(0, 0, 0, 1, 0, 0, 9, 1, 3, 0);
    tick();
    idle(9, 0);
    check("pre_reset_busy", 32'(o_rs1_busy), 32'h1);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("async_reset_busy", 32'(o_rs1_busy), 32'h0);
    check("async_reset_tag", 32'(o_rs1_tag), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(9, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
